shift_add_mult_ctrl: RTL and testbench

SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

---
 rtl/shift_add_mult_ctrl.sv | 89 ++++++++
 tb/tb_shift_add_mult_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for an N-bit shift/add multiplier: sequences load, N add/shift
// iterations and a one-cycle done pulse while the product is held.
module shift_add_mult_ctrl #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic A0,
   output logic LOAD_A,
   output logic LOAD_B,
   output logic init_P,
   output logic LOAD_P,
   output logic SHIFT_A,
   output logic select,
   output logic busy,
   output logic done
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic            calc;

   // Only the adder select follows A0 combinationally; everything else is registered.
   assign select = calc & A0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         calc    <= 1'b0;
         LOAD_A  <= 1'b0;
         LOAD_B  <= 1'b0;
         init_P  <= 1'b0;
         LOAD_P  <= 1'b0;
         SHIFT_A <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= LOAD;
                  LOAD_A <= 1'b1;
                  LOAD_B <= 1'b1;
                  init_P <= 1'b1;
                  busy   <= 1'b1;
               end
            end
            LOAD: begin
               state   <= CALC;
               cnt     <= '0;
               LOAD_A  <= 1'b0;
               LOAD_B  <= 1'b0;
               init_P  <= 1'b0;
               LOAD_P  <= 1'b1;
               SHIFT_A <= 1'b1;
               calc    <= 1'b1;
            end
            CALC: begin
               // Counter holds at N-1 on exit so it never wraps.
               if (cnt == LAST) begin
                  state   <= DONE;
                  LOAD_P  <= 1'b0;
                  SHIFT_A <= 1'b0;
                  calc    <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: drives a behavioural shift/add datapath and
// compares control outputs, timing and products against an arithmetic model.
module tb_shift_add_mult_ctrl;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n, start, A0;
   logic LOAD_A, LOAD_B, init_P, LOAD_P, SHIFT_A, select, busy, done;

   logic [N-1:0] a_bus, b_bus, a_reg, b_reg, p_reg;
   logic [N:0]   sum;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int last_done = 0;
   bit chain    = 1'b0;
   logic prev_done = 1'b0;

   shift_add_mult_ctrl #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .A0(A0),
      .LOAD_A(LOAD_A), .LOAD_B(LOAD_B), .init_P(init_P), .LOAD_P(LOAD_P),
      .SHIFT_A(SHIFT_A), .select(select), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Datapath the controller is meant to steer.
   assign A0  = a_reg[0];
   assign sum = {1'b0, p_reg} + (select ? {1'b0, b_reg} : '0);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (LOAD_A)  a_reg <= a_bus;
      if (LOAD_B)  b_reg <= b_bus;
      if (init_P)  p_reg <= '0;
      if (LOAD_P)  p_reg <= sum[N:1];
      if (SHIFT_A) a_reg <= {sum[0], a_reg[N-1:1]};
   end

   wire [7:0] outs = {LOAD_A, LOAD_B, init_P, LOAD_P, SHIFT_A, select, busy, done};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Invariants that must hold on every clocked cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         check_val("done_twice", {31'b0, done & prev_done}, 0);
         check_val("excl", {31'b0, (init_P & LOAD_P) | (LOAD_A & SHIFT_A)}, 0);
         check_val("sel_outside_calc", {31'b0, select & ~(LOAD_P & SHIFT_A & busy)}, 0);
         if (done) done_cnt++;
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   // One multiply: expected control vector per cycle derived from the
   // sequence IDLE, LOAD, N x CALC (select = bit i of A), DONE.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit hold, input bit pre);
      logic [7:0] exp;
      if (!pre) begin
         @(negedge clk);
         check_val("idle", {24'b0, outs}, 0);
         a_bus = a;
         b_bus = b;
         start = 1'b1;
      end
      @(negedge clk);
      check_val("load", {24'b0, outs}, 32'h0000_00E2);
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         exp = {5'b00011, a[i], 2'b10};
         check_val("calc", {24'b0, outs}, {24'b0, exp});
         start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check_val("done", {24'b0, outs}, 32'h0000_0001);
      check_val("product", {24'b0, p_reg, a_reg}, 32'(a) * 32'(b));
      if (chain) check_val("done_spacing", cyc - last_done, N + 3);
      last_done = cyc;
      chain = hold;
      start = hold;
   endtask

   initial begin
      int saved;
      rst_n = 1'b0;
      start = 1'b0;
      a_bus = '0;
      b_bus = '0;
      #1;
      check_val("reset_outs", {24'b0, outs}, 0);
      repeat (2) @(negedge clk);
      check_val("reset_hold", {24'b0, outs}, 0);
      #1 rst_n = 1'b1;

      run_op(4'd13, 4'd11, 1'b0, 1'b0);
      run_op(4'd15, 4'd15, 1'b0, 1'b0);
      run_op(4'd0,  4'd9,  1'b0, 1'b0);

      run_op(4'd3, 4'd5, 1'b1, 1'b0);
      run_op(4'd7, 4'd7, 1'b1, 1'b0);
      run_op(4'd9, 4'd2, 1'b0, 1'b0);

      // Abort in the 2nd CALC cycle with an asynchronous reset pulse.
      chain = 1'b0;
      @(negedge clk);
      a_bus = 4'd10;
      b_bus = 4'd12;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("busy_before_abort", {31'b0, busy}, 1);
      #1 rst_n = 1'b0;
      #1 check_val("abort_async", {24'b0, outs}, 0);
      saved = done_cnt;
      @(posedge clk);
      #1 check_val("abort_held", {24'b0, outs}, 0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      a_bus = 4'd6;
      b_bus = 4'd4;
      start = 1'b1;
      run_op(4'd6, 4'd4, 1'b0, 1'b1);
      @(negedge clk);
      check_val("no_done_on_abort", done_cnt, saved + 1);

      for (int k = 0; k < 24; k++) begin
         run_op(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("final_idle", {24'b0, outs}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
